hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core. It sits beside the ID stage and tracks the destination registers of in-flight instructions in an internal shadow pipeline covering the EX, MEM and WB stages. From that state it drives the IF/ID and ID/EX stall and flush controls, and the EX-stage operand forwarding selects. It also keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- CNT_W, default 16: width of the stall and flush event counters.

Ports:
- Clk, input, 1: core clock; all state updates on the rising edge.
- Reset, input, 1: synchronous, active-high.
- IdValid, input, 1: IF/ID register holds a real instruction (0 = bubble).
- IdRs1, input, 5: source register 1 of the ID instruction, from the decoder.
- IdRs2, input, 5: source register 2 of the ID instruction, from the decoder.
- IdUseRs1, input, 1: ID instruction reads Rs1.
- IdUseRs2, input, 1: ID instruction reads Rs2.
- IdRd, input, 5: destination register of the ID instruction.
- IdRegWr, input, 1: ID instruction writes the register file.
- IdMemtoReg, input, 1: ID instruction is a load.
- ExRedirect, input, 1: taken branch or jal resolved in EX this cycle.
- StallIF, output, 1: hold the PC.
- StallID, output, 1: hold the IF/ID register.
- FlushID, output, 1: clear IF/ID to a bubble at the next edge.
- FlushEX, output, 1: load a bubble into ID/EX at the next edge.
- ForwardA, output, 2: operand A select for the EX instruction.
- ForwardB, output, 2: operand B select for the EX instruction.
- StallCnt, output, CNT_W: number of load-use stall cycles.
- FlushCnt, output, CNT_W: number of redirects.

## Operation
- State: three slots, EX, MEM and WB. Each slot holds {valid, rd, regwr, load}. The EX slot also holds {rs1, rs2, use1, use2}.
- A slot "writes r" when valid & regwr & rd!=0 & rd==r.
- Load-use hazard (LU): the EX slot is a load, and the EX slot writes IdRs1 with IdUseRs1, or writes IdRs2 with IdUseRs2. LU also requires IdValid.
- Redirect has priority over LU. While ExRedirect=1: StallIF=StallID=0, FlushID=1, FlushEX=1, and LU is ignored.
- When LU holds and there is no redirect: StallIF=StallID=1, FlushID=0, FlushEX=1.
- Otherwise all four stall/flush outputs are 0.
- ForwardA encoding: FWD_MEM (01) if the MEM slot writes ex.rs1 & ex.use1 & !mem.load. Else FWD_WB (10) if the WB slot writes ex.rs1 & ex.use1. Else FWD_REG (00). MEM takes priority over WB.
- ForwardB follows the same rules with rs2/use2.
- WB-slot forwarding carries either the load data or the ALU result; the datapath selects between them using its own MemtoReg.
- A load in MEM matching an EX source cannot occur, because LU has already inserted a bubble. In that case ForwardA/ForwardB are 00.
- Slot update on each edge, when Reset=0: WB<=MEM, MEM<=EX. EX<=bubble if FlushEX, else {IdValid, ID fields}. No state is held during a stall; the bubble advances.
- Counters: StallCnt+1 on every LU cycle that has no redirect. FlushCnt+1 on every ExRedirect cycle. Both saturate at all-ones and never wrap.
- Register x0 never causes a hazard or a forward.

## Timing
- Stall, flush and forward outputs are combinational from the slots and the ID inputs, valid in the same cycle. Slots update at the edge, with a 1-cycle latency from ID to the EX slot.
- A load-use hazard costs exactly 1 stall cycle. In the next cycle the load sits in WB and the consumer in EX, with Forward=10.
- A redirect costs 2 bubbles: the IF/ID and ID/EX contents are discarded.
- Reset=1: all slots are invalidated at the edge and both counters clear to 0. While Reset is high the outputs are forced to StallIF=StallID=0, FlushID=FlushEX=1, ForwardA=ForwardB=00.
- Reset asserted mid-stall or mid-redirect abandons the operation. The first cycle after reset sees empty slots, so no hazard is reported.
- Simultaneous LU and ExRedirect: the redirect wins, and StallCnt does not increment.

## Structure
- Shared package pipe_pkg holds:
  - the fwd_sel_t enum {FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10};
  - the slot_t struct, reused later by other pipeline control blocks.
- Sub-module sat_counter (parameter W; inputs Clk, Reset, inc; output cnt) is instantiated twice, once per counter.
- Hazard detection and forward-select logic stay flat inside hazard_ctrl.

## Test plan
- Load-use on Rs1: lw x5 in ID, then add x6,x5,x7 in ID the next cycle. Expect 1 cycle of StallIF=StallID=FlushEX=1, then ForwardA=10, and StallCnt=1.
- Back-to-back ALU: add x3 followed by sub x4,x3,x3. Expect no stall and ForwardA=ForwardB=01. A third instruction reading x3 gets 10.
- x0 and priority: a producer writing x0 gives no forward and no stall. MEM and WB both writing x9 gives Forward=01.
- Redirect together with LU: ExRedirect=1 in a cycle where LU holds. Expect FlushID=FlushEX=1, StallIF=0, FlushCnt+1, StallCnt unchanged.
- Saturation: CNT_W=2 with 5 stalls. Expect StallCnt to reach 3 and hold at 3.
- Reset mid-stall: assert Reset during an LU cycle. Outputs take their reset values, and the next cycle with a dependent ID instruction shows no stall.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: forwarding selects, shadow-pipeline slot
// record, and the slot match helpers used by the hazard logic.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwr;
    logic       load;
  } slot_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
  } src_t;

  // True when the slot will write architectural register r (x0 excluded).
  function automatic logic slot_writes(slot_t s, logic [4:0] r);
    return s.valid & s.regwr & (s.rd != 5'd0) & (s.rd == r);
  endfunction

  // Forward hit: slot writes r, the consumer reads r, and a load is only
  // accepted when the stage already holds its data.
  function automatic logic slot_fwd(slot_t s, logic [4:0] r, logic use_r,
                                    logic allow_load);
    return slot_writes(s, r) & use_r & (allow_load | ~s.load);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: clears on Reset, counts inc cycles, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count register with synchronous clear and saturation.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt <= {W{1'b0}};
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller beside ID: shadow EX/MEM/WB slots drive load-use stalls,
// redirect flushes and EX operand forwarding selects.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             IdValid,
  input  logic [4:0]       IdRs1,
  input  logic [4:0]       IdRs2,
  input  logic             IdUseRs1,
  input  logic             IdUseRs2,
  input  logic [4:0]       IdRd,
  input  logic             IdRegWr,
  input  logic             IdMemtoReg,
  input  logic             ExRedirect,
  output logic             StallIF,
  output logic             StallID,
  output logic             FlushID,
  output logic             FlushEX,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  slot_t    ex_r, mem_r, wb_r;
  src_t     ex_src_r;
  logic     lu_s;
  logic     stall_s, flush_id_s, flush_ex_s;
  fwd_sel_t fwd_a_s, fwd_b_s;

  // Load-use: the load in EX produces a register the ID instruction reads.
  always_comb begin
    lu_s = IdValid & ex_r.load &
           ((IdUseRs1 & slot_writes(ex_r, IdRs1)) |
            (IdUseRs2 & slot_writes(ex_r, IdRs2)));
  end

  // Stall/flush decision; a redirect overrides any load-use stall.
  always_comb begin
    stall_s    = 1'b0;
    flush_id_s = 1'b0;
    flush_ex_s = 1'b0;
    if (ExRedirect) begin
      flush_id_s = 1'b1;
      flush_ex_s = 1'b1;
    end else if (lu_s) begin
      stall_s    = 1'b1;
      flush_ex_s = 1'b1;
    end else begin
      stall_s    = 1'b0;
    end
  end

  // Forward selects for the EX instruction; MEM is the younger producer.
  always_comb begin
    fwd_a_s = FWD_REG;
    fwd_b_s = FWD_REG;
    if (slot_fwd(mem_r, ex_src_r.rs1, ex_src_r.use1, 1'b0)) begin
      fwd_a_s = FWD_MEM;
    end else if (slot_fwd(wb_r, ex_src_r.rs1, ex_src_r.use1, 1'b1)) begin
      fwd_a_s = FWD_WB;
    end else begin
      fwd_a_s = FWD_REG;
    end
    if (slot_fwd(mem_r, ex_src_r.rs2, ex_src_r.use2, 1'b0)) begin
      fwd_b_s = FWD_MEM;
    end else if (slot_fwd(wb_r, ex_src_r.rs2, ex_src_r.use2, 1'b1)) begin
      fwd_b_s = FWD_WB;
    end else begin
      fwd_b_s = FWD_REG;
    end
  end

  // While in reset the core is held flushed with no forwarding.
  always_comb begin
    if (Reset) begin
      StallIF  = 1'b0;
      StallID  = 1'b0;
      FlushID  = 1'b1;
      FlushEX  = 1'b1;
      ForwardA = 2'b00;
      ForwardB = 2'b00;
    end else begin
      StallIF  = stall_s;
      StallID  = stall_s;
      FlushID  = flush_id_s;
      FlushEX  = flush_ex_s;
      ForwardA = fwd_a_s;
      ForwardB = fwd_b_s;
    end
  end

  // Shadow pipeline advance; stalls never hold a slot, a bubble enters EX.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_r     <= '0;
      ex_src_r <= '0;
      mem_r    <= '0;
      wb_r     <= '0;
    end else begin
      wb_r  <= mem_r;
      mem_r <= ex_r;
      if (flush_ex_s) begin
        ex_r     <= '0;
        ex_src_r <= '0;
      end else begin
        ex_r     <= '{valid: IdValid, rd: IdRd, regwr: IdRegWr, load: IdMemtoReg};
        ex_src_r <= '{rs1: IdRs1, rs2: IdRs2, use1: IdUseRs1, use2: IdUseRs2};
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (lu_s & ~ExRedirect),
    .cnt   (StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (ExRedirect),
    .cnt   (FlushCnt)
  );

endmodule
